// File: rtl/univ_shift_reg_if.sv
// Signal bundle for univ_shift_reg: control/data inputs from the master,
// register contents, serial taps and burst handshake back from the slave.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic             shift_en;
    logic             dir;
    logic             rotate;
    logic             s_in_r;
    logic             s_in_l;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] p_out;
    logic             s_out_r;
    logic             s_out_l;
    logic             busy;
    logic             done;

    modport master (
        output load, shift_en, dir, rotate, s_in_r, s_in_l, start, cnt, p_in,
        input  p_out, s_out_r, s_out_l, busy, done
    );

    modport slave (
        input  load, shift_en, dir, rotate, s_in_r, s_in_l, start, cnt, p_in,
        output p_out, s_out_r, s_out_l, busy, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: parallel load, single shifts/rotates,
// and an autonomous burst engine that performs cnt shifts from one start pulse.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    univ_shift_reg_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic             rot_q,   rot_d;
    logic             done_q,  done_d;

    // One shift step; serial inputs are always the live ones, even mid-burst.
    function automatic logic [WIDTH-1:0] shift_once(
        input logic [WIDTH-1:0] d,
        input logic             left,
        input logic             rot,
        input logic             sin_r,
        input logic             sin_l
    );
        if (left)
            return {d[WIDTH-2:0], rot ? d[WIDTH-1] : sin_l};
        else
            return {rot ? d[0] : sin_r, d[WIDTH-1:1]};
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        done_d  = 1'b0;

        if (bus.load) begin
            data_d  = bus.p_in;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            data_d = shift_once(data_q, dir_q, rot_q, bus.s_in_r, bus.s_in_l);
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (bus.start) begin
            // A zero-length burst completes immediately without ever going busy.
            if (bus.cnt == '0) begin
                done_d = 1'b1;
            end else begin
                state_d = SHIFT;
                cnt_d   = bus.cnt;
                dir_d   = bus.dir;
                rot_d   = bus.rotate;
            end
        end else if (bus.shift_en) begin
            data_d = shift_once(data_q, bus.dir, bus.rotate, bus.s_in_r, bus.s_in_l);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
        end
    end

    assign bus.p_out   = data_q;
    assign bus.s_out_r = data_q[0];
    assign bus.s_out_l = data_q[WIDTH-1];
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4) using a
// scoreboard of expected p_out/busy/done values checked after each clock edge.
module tb_univ_shift_reg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] p;
        logic             busy;
        logic             done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic expect_next(input string tag, input logic [WIDTH-1:0] p,
                               input logic b, input logic d);
        exp_t e;
        e.tag = tag; e.p = p; e.busy = b; e.done = d;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (bus.p_out === e.p) else begin
                n_fail++;
                $error("FAIL %s p_out got %h expected %h", e.tag, bus.p_out, e.p);
            end
            n_assert++;
            assert (bus.busy === e.busy) else begin
                n_fail++;
                $error("FAIL %s busy got %b expected %b", e.tag, bus.busy, e.busy);
            end
            n_assert++;
            assert (bus.done === e.done) else begin
                n_fail++;
                $error("FAIL %s done got %b expected %b", e.tag, bus.done, e.done);
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s got %b expected %b", tag, got, want);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        rst = 1'b0;
        bus.load = 1'b0; bus.shift_en = 1'b0; bus.dir = 1'b0; bus.rotate = 1'b0;
        bus.s_in_r = 1'b0; bus.s_in_l = 1'b0; bus.start = 1'b0;
        bus.cnt = '0; bus.p_in = '0;
        @(posedge clk);
        #1;

        // Arbitrary contents, then two reset edges with a competing load.
        bus.load = 1'b1; bus.p_in = 8'hC3;
        expect_next("pre_rst_load", 8'hC3, 1'b0, 1'b0); tick();
        rst = 1'b1; bus.p_in = 8'h77;
        expect_next("rst_edge1", 8'h00, 1'b0, 1'b0); tick();
        expect_next("rst_edge2", 8'h00, 1'b0, 1'b0); tick();
        rst = 1'b0;

        // Left shift with serial fill, taps checked beforehand.
        bus.p_in = 8'hA5;
        expect_next("load_a5", 8'hA5, 1'b0, 1'b0); tick();
        bus.load = 1'b0;
        check_bit("s_out_l_a5", bus.s_out_l, 1'b1);
        check_bit("s_out_r_a5", bus.s_out_r, 1'b1);
        bus.shift_en = 1'b1; bus.dir = 1'b1; bus.rotate = 1'b0; bus.s_in_l = 1'b1;
        expect_next("shl_fill", 8'h4B, 1'b0, 1'b0); tick();
        check_bit("s_out_l_4b", bus.s_out_l, 1'b0);
        check_bit("s_out_r_4b", bus.s_out_r, 1'b1);

        // Right rotate twice.
        bus.shift_en = 1'b0; bus.load = 1'b1; bus.p_in = 8'h81;
        expect_next("load_81", 8'h81, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.shift_en = 1'b1; bus.dir = 1'b0; bus.rotate = 1'b1;
        expect_next("rotr_1", 8'hC0, 1'b0, 1'b0); tick();
        expect_next("rotr_2", 8'h60, 1'b0, 1'b0); tick();

        // Burst of 3 left shifts; shift_en held, live dir flipped, start re-pulsed while busy.
        bus.shift_en = 1'b0; bus.load = 1'b1; bus.p_in = 8'h0F;
        expect_next("load_0f", 8'h0F, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.shift_en = 1'b1; bus.start = 1'b1; bus.cnt = 4'd3;
        bus.dir = 1'b1; bus.rotate = 1'b0; bus.s_in_l = 1'b0;
        expect_next("burst3_start", 8'h0F, 1'b1, 1'b0); tick();
        bus.start = 1'b0; bus.dir = 1'b0; bus.s_in_r = 1'b1;
        expect_next("burst3_s1", 8'h1E, 1'b1, 1'b0); tick();
        bus.start = 1'b1;
        expect_next("burst3_s2", 8'h3C, 1'b1, 1'b0); tick();
        bus.start = 1'b0;
        expect_next("burst3_done", 8'h78, 1'b0, 1'b1); tick();
        bus.shift_en = 1'b0;
        expect_next("burst3_after", 8'h78, 1'b0, 1'b0); tick();

        // Zero-length burst.
        bus.load = 1'b1; bus.p_in = 8'h5A;
        expect_next("load_5a", 8'h5A, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.start = 1'b1; bus.cnt = 4'd0;
        expect_next("cnt0_done", 8'h5A, 1'b0, 1'b1); tick();
        bus.start = 1'b0;
        expect_next("cnt0_after", 8'h5A, 1'b0, 1'b0); tick();

        // Load aborts a burst on its second busy cycle, then a clean 2-shift burst.
        bus.load = 1'b1; bus.p_in = 8'hFF;
        expect_next("load_ff", 8'hFF, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.start = 1'b1; bus.cnt = 4'd5; bus.dir = 1'b0;
        bus.rotate = 1'b0; bus.s_in_r = 1'b0;
        expect_next("burst5_start", 8'hFF, 1'b1, 1'b0); tick();
        bus.start = 1'b0;
        expect_next("burst5_s1", 8'h7F, 1'b1, 1'b0); tick();
        bus.load = 1'b1; bus.p_in = 8'h3C;
        expect_next("abort_load", 8'h3C, 1'b0, 1'b0); tick();
        bus.load = 1'b0;
        expect_next("abort_after", 8'h3C, 1'b0, 1'b0); tick();
        bus.start = 1'b1; bus.cnt = 4'd2;
        expect_next("burst2_start", 8'h3C, 1'b1, 1'b0); tick();
        bus.start = 1'b0;
        expect_next("burst2_s1", 8'h1E, 1'b1, 1'b0); tick();
        expect_next("burst2_done", 8'h0F, 1'b0, 1'b1); tick();
        expect_next("burst2_after", 8'h0F, 1'b0, 1'b0); tick();

        // start and load together: load wins.
        bus.load = 1'b1; bus.start = 1'b1; bus.p_in = 8'hAA; bus.cnt = 4'd2;
        expect_next("ld_vs_start", 8'hAA, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.start = 1'b0;
        expect_next("ld_vs_start2", 8'hAA, 1'b0, 1'b0); tick();

        // Burst longer than WIDTH: 9 left rotates of 81 equal one rotate.
        bus.load = 1'b1; bus.p_in = 8'h81;
        expect_next("load_81b", 8'h81, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.start = 1'b1; bus.cnt = 4'd9; bus.dir = 1'b1; bus.rotate = 1'b1;
        expect_next("burst9_start", 8'h81, 1'b1, 1'b0); tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_bit("burst9_busy_last", bus.busy, 1'b1);
        expect_next("burst9_done", 8'h03, 1'b0, 1'b1); tick();

        // Reset in the middle of a burst: no done pulse afterwards.
        bus.load = 1'b1; bus.p_in = 8'h0F;
        expect_next("load_0f_b", 8'h0F, 1'b0, 1'b0); tick();
        bus.load = 1'b0; bus.start = 1'b1; bus.cnt = 4'd4; bus.dir = 1'b1; bus.rotate = 1'b1;
        expect_next("burst4_start", 8'h0F, 1'b1, 1'b0); tick();
        bus.start = 1'b0;
        expect_next("burst4_s1", 8'h1E, 1'b1, 1'b0); tick();
        rst = 1'b1;
        expect_next("mid_rst", 8'h00, 1'b0, 1'b0); tick();
        rst = 1'b0;
        expect_next("mid_rst_after1", 8'h00, 1'b0, 1'b0); tick();
        expect_next("mid_rst_after2", 8'h00, 1'b0, 1'b0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the 4-bit PIPO block to WIDTH bits and supports parallel load, left/right shift, rotate, and serial taps at both ends. It adds an autonomous burst-shift engine that performs N shifts from a single start pulse, with busy/done handshake. It is intended for serialisers, bit-reversal, and barrel-style datapath helpers.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst count input; max burst = 2^CNT_W-1 shifts

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
load  input  1  parallel load p_in (highest functional priority)
shift_en  input  1  single shift this cycle (ignored while busy)
dir  input  1  0 = right (toward LSB), 1 = left (toward MSB)
rotate  input  1  1 = wrap the outgoing bit back in; 0 = use serial input
s_in_r  input  1  serial in for right shift (enters MSB)
s_in_l  input  1  serial in for left shift (enters LSB)
start  input  1  begin burst of cnt shifts
cnt  input  CNT_W  burst length
p_in  input  WIDTH  parallel data
p_out  output  WIDTH  register contents
s_out_r  output  1  p_out[0], combinational tap
s_out_l  output  1  p_out[WIDTH-1], combinational tap
busy  output  1  burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset: single clock (clk). rst is synchronous and active-high. At a clk edge with rst=1: p_out=0, busy=0, done=0, FSM=IDLE, internal counter=0. rst has priority over every other input, including mid-burst.
- Priority per edge: rst > load > active burst > start > shift_en > hold.
- Right shift: p_out <= {rotate ? p_out[0] : s_in_r, p_out[WIDTH-1:1]}.
- Left shift: p_out <= {p_out[WIDTH-2:0], rotate ? p_out[WIDTH-1] : s_in_l}.
- shift_en: one shift at that edge using live dir/rotate. No effect when busy=1.
- done is a registered output. It defaults to 0 every cycle unless set by a rule below.
- FSM has two states, IDLE and SHIFT.
- IDLE, start=1, cnt=N>0, load=0:
  - Latch dir/rotate, set remaining=N, busy<=1; no shift at this edge.
  - Enter SHIFT. Serial inputs are sampled live during the burst.
- IDLE, start=1, cnt=0, load=0: done<=1 for one cycle, busy stays 0, p_out unchanged.
- SHIFT: each edge performs one shift using the latched dir/rotate and decrements remaining.
- SHIFT completion: on the edge where remaining goes 1->0, do the final shift, busy<=0, done<=1, and return to IDLE.
- Burst timing: start sampled at edge k. Shifts occur at edges k+1..k+N. busy is high for exactly N cycles. done is high the single cycle after edge k+N, coincident with busy falling and the final p_out.
- start while busy: ignored, no restart or queueing.
- load while busy: p_out<=p_in, burst aborted, busy<=0, done stays 0, FSM->IDLE.
- start and load in the same IDLE cycle: load wins, start discarded.
- start and shift_en in the same IDLE cycle: start wins, no shift that edge.
- cnt > WIDTH is legal: shifting continues (rotate cycles the data; otherwise serial fill).
- No combinational path from inputs to p_out/busy/done. s_out_r/s_out_l decode p_out only.

Test Plan:
- Assert rst for 2 edges after arbitrary p_out -> p_out=8'h00, busy=0, done=0. Also assert rst mid-burst -> same values, no done pulse.
- Load 8'hA5, then shift_en=1, dir=1, rotate=0, s_in_l=1 for one edge -> p_out=8'h4B. Before that edge s_out_l=1 and s_out_r=1.
- Load 8'h81, then shift_en=1, dir=0, rotate=1 -> p_out=8'hC0. A second right rotate -> 8'h60.
- Load 8'h0F, then start=1, cnt=3, dir=1, rotate=0, s_in_l=0 -> busy high exactly 3 cycles, done pulses once with p_out=8'h78. shift_en=1 held throughout has no extra effect.
- start=1 with cnt=0 on p_out=8'h5A -> done=1 next cycle, busy never 1, p_out=8'h5A.
- Load 8'hFF, start cnt=5 dir=0 s_in_r=0; on the 2nd busy cycle load=1 p_in=8'h3C -> p_out=8'h3C, busy=0 next cycle, done never asserted. A subsequent start with cnt=2 (right, s_in_r=0) -> 8'h0F with done.
